// File: rtl/chan_mux_pipe.sv
// chan_mux_pipe: registered N:1 channel selector with a STAGES-deep output
// pipeline. A channel switch drains the pipeline and inserts a guard band,
// so words from the old and new channels never interleave at data_out.
//
// Switch handshake: sel_load is a one-cycle strobe sampled with sel_req.
// A request is taken only in RUN with an in-range sel_req that differs
// from sel_cur. Taking it raises sel_busy on the following cycle, and
// sel_busy stays high until the edge that updates sel_cur. A strobe that
// arrives while busy, or that names a channel >= NCH, is rejected with a
// registered one-cycle sel_err pulse. A strobe that names the current
// channel is a silent no-op. There is no backpressure anywhere.
module chan_mux_pipe #(
    parameter int WIDTH  = 8,
    parameter int NCH    = 4,
    parameter int STAGES = 2,
    parameter int GUARD  = 2,
    parameter int SW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] data_in,
    input  logic [NCH-1:0]       in_valid,
    input  logic [SW-1:0]        sel_req,
    input  logic                 sel_load,
    output logic [SW-1:0]        sel_cur,
    output logic                 sel_busy,
    output logic                 sel_err,
    output logic [WIDTH-1:0]     data_out,
    output logic                 out_valid,
    output logic [1:0]           dbg_state
);

    // FSM encoding. RUN is all-zero, so the reset state reads as 0 on dbg_state.
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    // The bubble counter must hold the larger of STAGES and GUARD.
    localparam int CNT_MAX = (STAGES > GUARD) ? STAGES : GUARD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_STAGES = CW'(STAGES);
    localparam logic [CW-1:0] CNT_GUARD  = CW'(GUARD);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = '0;

    // sel_req is extended by one bit so the range check stays correct
    // even when NCH is an exact power of two.
    localparam logic [SW:0] NCH_W = (SW + 1)'(NCH);

    // Control state.
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [SW-1:0] pend_q,  pend_d;
    logic [SW-1:0] cur_q,   cur_d;
    logic          err_q,   err_d;

    // Pipeline state. Index 0 is the capture stage; STAGES-1 drives the outputs.
    logic             pv_q [STAGES];
    logic             pv_d [STAGES];
    logic [WIDTH-1:0] pd_q [STAGES];
    logic [WIDTH-1:0] pd_d [STAGES];

    // Input routing.
    logic [WIDTH-1:0] chan_words [NCH];
    logic             req_in_range;
    logic             s0_valid;
    logic [WIDTH-1:0] s0_data;

    // Split the flat input bus into per-channel words.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            chan_words[k] = data_in[k*WIDTH +: WIDTH];
        end
    end

    // Select the routed channel. Outside RUN, stage 0 sees a bubble.
    always_comb begin
        req_in_range = ({1'b0, sel_req} < NCH_W);
        s0_data      = chan_words[cur_q];
        s0_valid     = (state_q == ST_RUN) && in_valid[cur_q];
    end

    // Switch sequencer: RUN -> DRAIN (STAGES bubbles) -> GUARD (GUARD bubbles) -> RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        cur_d   = cur_q;
        err_d   = 1'b0;

        // Any strobe outside RUN is rejected. The pending request is kept.
        if (sel_load && (state_q != ST_RUN)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (sel_load) begin
                    if (!req_in_range) begin
                        err_d = 1'b1;
                    end else if (sel_req != cur_q) begin
                        pend_d  = sel_req;
                        state_d = ST_DRAIN;
                        cnt_d   = CNT_STAGES;
                    end
                end
            end

            ST_DRAIN: begin
                if (cnt_q == CNT_ONE) begin
                    if (GUARD == 0) begin
                        // No guard band: the new channel takes effect now.
                        state_d = ST_RUN;
                        cnt_d   = CNT_ZERO;
                        cur_d   = pend_q;
                    end else begin
                        state_d = ST_GUARD;
                        cnt_d   = CNT_GUARD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_GUARD: begin
                if (cnt_q == CNT_ONE) begin
                    // sel_cur switches on the same edge that re-enters RUN.
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                    cur_d   = pend_q;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                // Unreachable encoding: recover to RUN on the current channel.
                state_d = ST_RUN;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Register the control state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= CNT_ZERO;
            pend_q  <= '0;
            cur_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            cur_q   <= cur_d;
            err_q   <= err_d;
        end
    end

    // Pipeline next state: valid bits always shift, data loads only with valid.
    always_comb begin
        pv_d[0] = s0_valid;
        pd_d[0] = s0_valid ? s0_data : pd_q[0];
        for (int i = 1; i < STAGES; i++) begin
            pv_d[i] = pv_q[i-1];
            pd_d[i] = pv_q[i-1] ? pd_q[i-1] : pd_q[i];
        end
    end

    // Register the pipeline. Data is cleared on reset so data_out reads 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                pv_q[i] <= 1'b0;
                pd_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                pv_q[i] <= pv_d[i];
                pd_q[i] <= pd_d[i];
            end
        end
    end

    // Drive the outputs straight from registers.
    always_comb begin
        sel_cur   = cur_q;
        sel_busy  = (state_q != ST_RUN);
        sel_err   = err_q;
        data_out  = pd_q[STAGES-1];
        out_valid = pv_q[STAGES-1];
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_chan_mux_pipe.sv
// Bench for chan_mux_pipe. DUT A uses the defaults (NCH=4, STAGES=2,
// GUARD=2). DUT B uses NCH=5 and GUARD=0. Expected words and arrival
// cycles are queued when stimulus is driven, then popped as words appear.
module tb_chan_mux_pipe;

    localparam int S = 2;

    // Clock and reset.
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // DUT A signals.
    logic [31:0] a_data_in;
    logic [3:0]  a_in_valid;
    logic [1:0]  a_sel_req;
    logic        a_sel_load;
    logic [1:0]  a_sel_cur;
    logic        a_sel_busy, a_sel_err, a_out_valid;
    logic [7:0]  a_data_out;
    logic [1:0]  a_dbg_state;

    // DUT B signals.
    logic [39:0] b_data_in;
    logic [4:0]  b_in_valid;
    logic [2:0]  b_sel_req;
    logic        b_sel_load;
    logic [2:0]  b_sel_cur;
    logic        b_sel_busy, b_sel_err, b_out_valid;
    logic [7:0]  b_data_out;
    logic [1:0]  b_dbg_state;

    chan_mux_pipe #(.WIDTH(8), .NCH(4), .STAGES(S), .GUARD(2)) u_dut_a (
        .clk(clk), .reset(reset), .data_in(a_data_in), .in_valid(a_in_valid),
        .sel_req(a_sel_req), .sel_load(a_sel_load), .sel_cur(a_sel_cur),
        .sel_busy(a_sel_busy), .sel_err(a_sel_err), .data_out(a_data_out),
        .out_valid(a_out_valid), .dbg_state(a_dbg_state)
    );

    chan_mux_pipe #(.WIDTH(8), .NCH(5), .STAGES(S), .GUARD(0)) u_dut_b (
        .clk(clk), .reset(reset), .data_in(b_data_in), .in_valid(b_in_valid),
        .sel_req(b_sel_req), .sel_load(b_sel_load), .sel_cur(b_sel_cur),
        .sel_busy(b_sel_busy), .sel_err(b_sel_err), .data_out(b_data_out),
        .out_valid(b_out_valid), .dbg_state(b_dbg_state)
    );

    // Counters and scoreboards.
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] exp_a_q[$];
    int         due_a_q[$];
    logic [7:0] exp_b_q[$];
    int         due_b_q[$];
    logic [7:0] a_last, b_last;

    // Reference routing state: current channel, pending channel, bubbles left.
    int a_cur, a_nxt, a_bub;
    int b_cur, b_nxt, b_bub;

    // Segment statistics.
    int a_busy_n, a_low_n, a_low_run, a_low_max, a_err_n;
    int b_busy_n, b_err_n;
    logic a_saw1;

    function automatic logic [7:0] rnd8();
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predict one clock edge. Capture at the sampling edge still uses the old
    // channel. The next STAGES+GUARD captures are bubbles. The channel changes
    // on the last bubble edge.
    task automatic model_edge(input int nch, input int ng, input logic [39:0] d,
                              input logic [4:0] v, input logic ld, input logic [2:0] req,
                              inout int cur, inout int nxt, inout int bub,
                              output logic push, output logic [7:0] word, output logic err);
        logic busy;
        push = 1'b0;
        word = 8'h00;
        err  = 1'b0;
        busy = (bub > 0);
        if (busy) begin
            bub--;
            if (bub == 0) cur = nxt;
        end else if (v[cur]) begin
            push = 1'b1;
            word = d[cur*8 +: 8];
        end
        if (ld) begin
            if (busy || int'(req) >= nch) err = 1'b1;
            else if (int'(req) != cur) begin
                nxt = int'(req);
                bub = S + ng;
            end
        end
    endtask

    task automatic seg_clear();
        a_busy_n = 0; a_low_n = 0; a_low_run = 0; a_low_max = 0; a_err_n = 0; a_saw1 = 1'b0;
        b_busy_n = 0; b_err_n = 0;
    endtask

    // One clock: predict and queue, advance the edge, then check both DUTs.
    task automatic step();
        logic pa, pb, ea, eb;
        logic [7:0] wa, wb, w;
        int t;
        model_edge(4, 2, {8'h00, a_data_in}, {1'b0, a_in_valid}, a_sel_load, {1'b0, a_sel_req},
                   a_cur, a_nxt, a_bub, pa, wa, ea);
        if (pa) begin exp_a_q.push_back(wa); due_a_q.push_back(cyc + S); end
        model_edge(5, 0, b_data_in, b_in_valid, b_sel_load, b_sel_req,
                   b_cur, b_nxt, b_bub, pb, wb, eb);
        if (pb) begin exp_b_q.push_back(wb); due_b_q.push_back(cyc + S); end

        @(posedge clk);
        #1;
        cyc++;
        a_sel_load = 1'b0;
        b_sel_load = 1'b0;

        check("a_sel_cur", 32'(a_sel_cur), 32'(a_cur));
        check("a_sel_busy", 32'(a_sel_busy), 32'(a_bub > 0));
        check("a_sel_err", 32'(a_sel_err), 32'(ea));
        check("b_sel_cur", 32'(b_sel_cur), 32'(b_cur));
        check("b_sel_busy", 32'(b_sel_busy), 32'(b_bub > 0));
        check("b_sel_err", 32'(b_sel_err), 32'(eb));

        if (a_out_valid) begin
            if (exp_a_q.size() == 0) check("a_unexpected_word", 32'(a_out_valid), 32'(0));
            else begin
                w = exp_a_q.pop_front(); t = due_a_q.pop_front();
                check("a_data", 32'(a_data_out), 32'(w));
                check("a_latency", 32'(cyc), 32'(t));
                a_last = w;
            end
        end else begin
            check("a_hold", 32'(a_data_out), 32'(a_last));
            if (exp_a_q.size() > 0 && due_a_q[0] <= cyc) begin
                check("a_missing_word", 32'(a_out_valid), 32'(1));
                void'(exp_a_q.pop_front()); void'(due_a_q.pop_front());
            end
        end

        if (b_out_valid) begin
            if (exp_b_q.size() == 0) check("b_unexpected_word", 32'(b_out_valid), 32'(0));
            else begin
                w = exp_b_q.pop_front(); t = due_b_q.pop_front();
                check("b_data", 32'(b_data_out), 32'(w));
                check("b_latency", 32'(cyc), 32'(t));
                b_last = w;
            end
        end else begin
            check("b_hold", 32'(b_data_out), 32'(b_last));
            if (exp_b_q.size() > 0 && due_b_q[0] <= cyc) begin
                check("b_missing_word", 32'(b_out_valid), 32'(1));
                void'(exp_b_q.pop_front()); void'(due_b_q.pop_front());
            end
        end

        if (a_sel_busy) a_busy_n++;
        if (a_sel_err) a_err_n++;
        if (a_sel_cur == 2'd1) a_saw1 = 1'b1;
        if (!a_out_valid) begin
            a_low_n++; a_low_run++;
            if (a_low_run > a_low_max) a_low_max = a_low_run;
        end else a_low_run = 0;
        if (b_sel_busy) b_busy_n++;
        if (b_sel_err) b_err_n++;
    endtask

    // Assert reset between edges, check the asynchronous clear, then release away from the edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("a_rst_sel_cur", 32'(a_sel_cur), 32'(0));
        check("a_rst_busy", 32'(a_sel_busy), 32'(0));
        check("a_rst_err", 32'(a_sel_err), 32'(0));
        check("a_rst_out_valid", 32'(a_out_valid), 32'(0));
        check("a_rst_data_out", 32'(a_data_out), 32'(0));
        check("a_rst_state", 32'(a_dbg_state), 32'(0));
        check("b_rst_sel_cur", 32'(b_sel_cur), 32'(0));
        check("b_rst_out_valid", 32'(b_out_valid), 32'(0));
        check("b_rst_data_out", 32'(b_data_out), 32'(0));
        exp_a_q.delete(); due_a_q.delete(); exp_b_q.delete(); due_b_q.delete();
        a_cur = 0; a_nxt = 0; a_bub = 0; a_last = 8'h00;
        b_cur = 0; b_nxt = 0; b_bub = 0; b_last = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        a_in_valid = 4'b0000;
        b_in_valid = 5'b00000;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        a_data_in = '0; a_in_valid = '0; a_sel_req = '0; a_sel_load = 1'b0;
        b_data_in = '0; b_in_valid = '0; b_sel_req = '0; b_sel_load = 1'b0;
        seg_clear();
        #2;
        do_reset();

        // Stream channel 0 words 0x10..0x1F; other channels carry noise.
        for (int i = 0; i < 16; i++) begin
            if (i == 2) seg_clear();
            a_data_in  = {rnd8(), rnd8(), rnd8(), 8'(8'h10 + i)};
            a_in_valid = {3'($urandom_range(0, 7)), 1'b1};
            step();
        end
        check("t1_no_gap", 32'(a_low_n), 32'(0));
        idle(4);

        // Switch ch0 -> ch2 while both stream. A request for ch1 arrives mid-switch.
        for (int i = 0; i < 16; i++) begin
            if (i == 3) seg_clear();
            a_data_in  = {rnd8(), 8'(8'hC0 + i), rnd8(), 8'(8'hA0 + i)};
            a_in_valid = 4'b1111;
            if (i == 3) begin a_sel_load = 1'b1; a_sel_req = 2'd2; end
            if (i == 5) begin a_sel_load = 1'b1; a_sel_req = 2'd1; end
            step();
        end
        check("t2_busy_cycles", 32'(a_busy_n), 32'(4));
        check("t2_gap_run", 32'(a_low_max), 32'(4));
        check("t2_gap_total", 32'(a_low_n), 32'(4));
        check("t2_err_pulses", 32'(a_err_n), 32'(1));
        check("t2_never_ch1", 32'(a_saw1), 32'(0));
        check("t2_sel_cur", 32'(a_sel_cur), 32'(2));
        idle(4);

        // Requesting the current channel changes nothing.
        for (int i = 0; i < 10; i++) begin
            if (i == 3) seg_clear();
            a_data_in  = {rnd8(), 8'(8'h30 + i), rnd8(), rnd8()};
            a_in_valid = 4'b0100;
            if (i == 3) begin a_sel_load = 1'b1; a_sel_req = 2'd2; end
            step();
        end
        check("t3_no_busy", 32'(a_busy_n), 32'(0));
        check("t3_no_gap", 32'(a_low_n), 32'(0));
        check("t3_no_err", 32'(a_err_n), 32'(0));
        idle(4);

        // NCH=5, GUARD=0: out-of-range request, then switch to ch4.
        for (int i = 0; i < 14; i++) begin
            if (i == 3) seg_clear();
            b_data_in  = {8'(8'h60 + i), rnd8(), rnd8(), rnd8(), 8'(8'h50 + i)};
            b_in_valid = 5'b11111;
            if (i == 3) begin b_sel_load = 1'b1; b_sel_req = 3'd7; end
            if (i == 5) begin b_sel_load = 1'b1; b_sel_req = 3'd4; end
            step();
        end
        check("t4_err_pulses", 32'(b_err_n), 32'(1));
        check("t4_busy_cycles", 32'(b_busy_n), 32'(2));
        check("t4_sel_cur", 32'(b_sel_cur), 32'(4));
        idle(4);

        // Reset one cycle into DRAIN of a ch2 -> ch1 switch.
        for (int i = 0; i < 4; i++) begin
            a_data_in  = {rnd8(), 8'(8'h80 + i), rnd8(), rnd8()};
            a_in_valid = 4'b0101;
            if (i == 2) begin a_sel_load = 1'b1; a_sel_req = 2'd1; end
            step();
        end
        check("t5_in_drain", 32'(a_dbg_state), 32'(1));
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a_data_in  = {rnd8(), rnd8(), rnd8(), 8'(8'h90 + i)};
            a_in_valid = 4'b0001;
            step();
        end
        idle(4);

        check("a_queue_empty", 32'(exp_a_q.size()), 32'(0));
        check("b_queue_empty", 32'(exp_b_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
